ign_dwell_sched: RTL and testbench

IGN_DWELL_SCHED -- requirements
Module: ign_dwell_sched

---
 rtl/hwag_pkg.sv | 14 +
 rtl/d_flip_flop.sv | 22 ++
 rtl/ign_dwell_sched.sv | 182 ++++++++++++++++++
 tb/tb_ign_dwell_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// Shared definitions for the angle-generator ignition blocks: dwell scheduler
// FSM states and default data sizing.
package hwag_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE,
    ST_DONE
  } state_t;

  localparam int WIDTH_DFLT   = 24;
  localparam int ANG_MAX_DFLT = 7679;
endpackage

// File: rtl/d_flip_flop.sv
// Enabled register with asynchronous active-high clear; one per ignition channel
// holds the committed dwell angle.
module d_flip_flop #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  always_comb q_d = en ? d : q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/ign_dwell_sched.sv
// Converts per-channel dwell times into crank angles by time-sharing one external
// divider; results land in shadow registers and are committed on the next tooth.
module ign_dwell_sched
  import hwag_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH   = WIDTH_DFLT,
  parameter int ANG_MAX = ANG_MAX_DFLT,
  parameter int TMO     = 63
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hwag_start,
  input  logic                  main_edge,
  input  logic [21:0]           scnt_load,
  input  logic [N_CH*WIDTH-1:0] dwell_time,
  input  logic [N_CH-1:0]       ch_ena,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divider,
  input  logic [WIDTH-1:0]      div_result,
  input  logic                  div_rdy,
  output logic [N_CH*WIDTH-1:0] angle_set,
  output logic                  busy,
  output logic                  upd,
  output logic                  err_zero,
  output logic                  err_tmo,
  output logic                  overrun
);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [WIDTH-1:0] ANG_CLAMP = WIDTH'(ANG_MAX);

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [TW-1:0]              wcnt_q, wcnt_d;
  logic                       pending_q, pending_d;
  logic [N_CH-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic                       div_start_q, div_start_d;
  logic [WIDTH-1:0]           div_dividend_q, div_dividend_d;
  logic [WIDTH-1:0]           div_divider_q, div_divider_d;
  logic                       upd_q, upd_d;
  logic                       err_zero_q, err_zero_d;
  logic                       err_tmo_q, err_tmo_d;
  logic                       overrun_q, overrun_d;

  logic [N_CH-1:0][WIDTH-1:0] dwell_v, bank_d, ang_q;
  logic abort, commit, is_last, ch_on, zero_div, rdy_ok, tmo_hit, bank_en;
  logic [WIDTH-1:0] res_clamped;

  assign dwell_v     = dwell_time;
  assign abort       = ~hwag_start;
  assign commit      = main_edge & pending_q & hwag_start;
  assign is_last     = idx_q == IW'(N_CH - 1);
  assign ch_on       = ch_ena[idx_q];
  assign zero_div    = div_divider_q == '0;
  // The first WAIT cycle may still see the previous quotient's level-valid flag.
  assign rdy_ok      = (wcnt_q != '0) & div_rdy;
  assign tmo_hit     = ~rdy_ok & (wcnt_q == TW'(TMO - 1));
  assign res_clamped = (div_result > ANG_CLAMP) ? ANG_CLAMP : div_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      wcnt_q         <= '0;
      pending_q      <= 1'b0;
      shadow_q       <= '0;
      div_start_q    <= 1'b0;
      div_dividend_q <= '0;
      div_divider_q  <= '0;
      upd_q          <= 1'b0;
      err_zero_q     <= 1'b0;
      err_tmo_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      wcnt_q         <= wcnt_d;
      pending_q      <= pending_d;
      shadow_q       <= shadow_d;
      div_start_q    <= div_start_d;
      div_dividend_q <= div_dividend_d;
      div_divider_q  <= div_divider_d;
      upd_q          <= upd_d;
      err_zero_q     <= err_zero_d;
      err_tmo_q      <= err_tmo_d;
      overrun_q      <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE:  if (main_edge) state_d = ST_ISSUE;
        ST_ISSUE: state_d = (ch_on && !zero_div) ? ST_WAIT : ST_STORE;
        ST_WAIT:  if (rdy_ok || tmo_hit) state_d = ST_STORE;
        ST_STORE: state_d = is_last ? ST_DONE : ST_ISSUE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_d          = idx_q;
    wcnt_d         = wcnt_q;
    pending_d      = pending_q;
    shadow_d       = shadow_q;
    div_start_d    = 1'b0;
    div_dividend_d = div_dividend_q;
    div_divider_d  = div_divider_q;
    upd_d          = 1'b0;
    err_zero_d     = err_zero_q;
    err_tmo_d      = err_tmo_q;
    overrun_d      = overrun_q;
    if (main_edge && state_q != ST_IDLE) overrun_d = 1'b1;
    if (abort) begin
      pending_d = 1'b0;
      shadow_d  = '0;
      idx_d     = '0;
    end else begin
      if (commit) begin
        upd_d     = 1'b1;
        pending_d = 1'b0;
      end
      case (state_q)
        ST_IDLE: if (main_edge) begin
          div_divider_d = {{(WIDTH-22){1'b0}}, scnt_load};
          idx_d         = '0;
        end
        ST_ISSUE: begin
          if (!ch_on) shadow_d[idx_q] = '0;
          else if (zero_div) begin
            shadow_d[idx_q] = ANG_CLAMP;
            err_zero_d      = 1'b1;
          end else begin
            div_start_d    = 1'b1;
            div_dividend_d = dwell_v[idx_q];
            wcnt_d         = '0;
          end
        end
        ST_WAIT: begin
          if (rdy_ok)       shadow_d[idx_q] = res_clamped;
          else if (tmo_hit) err_tmo_d = 1'b1;
          else              wcnt_d = wcnt_q + TW'(1);
        end
        ST_STORE: if (!is_last) idx_d = idx_q + IW'(1);
        ST_DONE:  pending_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Abort clears the committed bank too; otherwise it loads only on commit.
  always_comb begin
    bank_en = abort | commit;
    bank_d  = abort ? '0 : shadow_q;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_bank
    d_flip_flop #(.W(WIDTH)) u_ang (
      .clk (clk),
      .rst (rst),
      .en  (bank_en),
      .d   (bank_d[i]),
      .q   (ang_q[i])
    );
  end

  assign angle_set    = ang_q;
  assign busy         = state_q != ST_IDLE;
  assign div_start    = div_start_q;
  assign div_dividend = div_dividend_q;
  assign div_divider  = div_divider_q;
  assign upd          = upd_q;
  assign err_zero     = err_zero_q;
  assign err_tmo      = err_tmo_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_ign_dwell_sched.sv
// Randomized bench for ign_dwell_sched with a latency-programmable divider model
// and a pass-level reference model of the expected angles and timing.
module tb_ign_dwell_sched;
  localparam int N_CH = 4, WIDTH = 24, ANG_MAX = 7679, TMO = 63;

  logic clk = 1'b0, rst = 1'b1, hwag_start = 1'b0, main_edge = 1'b0;
  logic [21:0] scnt_load = '0;
  logic [N_CH*WIDTH-1:0] dwell_time = '0;
  logic [N_CH-1:0] ch_ena = '0;
  logic div_start, div_rdy = 1'b0;
  logic [WIDTH-1:0] div_dividend, div_divider, div_result = '0;
  logic [N_CH*WIDTH-1:0] angle_set;
  logic busy, upd, err_zero, err_tmo, overrun;

  int checks = 0, errors = 0;
  int lat = 4;
  bit never_rdy = 1'b0;
  int ds_total = 0, upd_total = 0;
  int exp_shadow[N_CH];
  int cnt = 0;
  bit clr_pend = 1'b0;
  logic [WIDTH-1:0] next_res = '0;

  always #5 clk = ~clk;

  ign_dwell_sched #(.N_CH(N_CH), .WIDTH(WIDTH), .ANG_MAX(ANG_MAX), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .hwag_start(hwag_start), .main_edge(main_edge),
    .scnt_load(scnt_load), .dwell_time(dwell_time), .ch_ena(ch_ena),
    .div_start(div_start), .div_dividend(div_dividend), .div_divider(div_divider),
    .div_result(div_result), .div_rdy(div_rdy), .angle_set(angle_set),
    .busy(busy), .upd(upd), .err_zero(err_zero), .err_tmo(err_tmo), .overrun(overrun)
  );

  // Divider: quotient valid lat cycles after div_start; the old level lingers one cycle.
  always @(negedge clk) begin
    if (rst) begin
      cnt = 0; clr_pend = 1'b0; div_rdy = 1'b0;
    end else if (div_start) begin
      next_res = (div_divider != '0) ? div_dividend / div_divider : '1;
      cnt = lat; clr_pend = 1'b1;
    end else begin
      if (clr_pend) begin div_rdy = 1'b0; clr_pend = 1'b0; end
      if (cnt > 0 && !never_rdy) begin
        cnt--;
        if (cnt == 0) begin div_rdy = 1'b1; div_result = next_res; end
      end
    end
  end

  always @(negedge clk) begin
    if (div_start) ds_total++;
    if (upd) upd_total++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_edge();
    main_edge = 1'b1; @(negedge clk); main_edge = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s wait_idle: busy still %b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic set_case(input int scnt, input int dw, input logic [N_CH-1:0] ena,
                          input int l, input bit nr, input bit rnd_dw);
    scnt_load = 22'(scnt); ch_ena = ena; lat = l; never_rdy = nr;
    for (int c = 0; c < N_CH; c++)
      dwell_time[c*WIDTH +: WIDTH] = rnd_dw ? WIDTH'($urandom_range(0, 3000000)) : WIDTH'(dw);
  endtask

  // Pass-level model: per channel disabled/zero-period take 2 cycles, a division
  // takes issue+wait(lat+1)+store, a timeout issue+TMO+store; plus one DONE cycle.
  task automatic predict(output int e_ds, output int e_cyc);
    e_ds = 0; e_cyc = 1;
    for (int c = 0; c < N_CH; c++) begin
      int dw, q;
      dw = int'(dwell_time[c*WIDTH +: WIDTH]);
      if (!ch_ena[c]) begin exp_shadow[c] = 0; e_cyc += 2; end
      else if (scnt_load == 0) begin exp_shadow[c] = ANG_MAX; e_cyc += 2; end
      else begin
        e_ds++;
        if (never_rdy) e_cyc += TMO + 2;
        else begin
          e_cyc += lat + 3;
          q = dw / int'(scnt_load);
          exp_shadow[c] = (q > ANG_MAX) ? ANG_MAX : q;
        end
      end
    end
  endtask

  task automatic run_pass(input string name, input bit mid_edge);
    int e_ds, e_cyc, ds0, cyc;
    predict(e_ds, e_cyc);
    ds0 = ds_total;
    pulse_edge();
    cyc = 0;
    while (busy && cyc < 4000) begin
      cyc++;
      main_edge = mid_edge && (cyc == 10);
      @(negedge clk);
    end
    main_edge = 1'b0;
    checks++;
    if (cyc !== e_cyc) begin errors++; $display("FAIL %s pass_cycles: got %0d expected %0d", name, cyc, e_cyc); end
    checks++;
    if (ds_total - ds0 !== e_ds) begin errors++; $display("FAIL %s div_start_count: got %0d expected %0d", name, ds_total - ds0, e_ds); end
  endtask

  task automatic commit_check(input string name);
    int u0;
    u0 = upd_total;
    pulse_edge();
    for (int c = 0; c < N_CH; c++) begin
      checks++;
      if (int'(angle_set[c*WIDTH +: WIDTH]) !== exp_shadow[c]) begin
        errors++;
        $display("FAIL %s angle_set ch%0d: got %0d expected %0d", name, c, angle_set[c*WIDTH +: WIDTH], exp_shadow[c]);
      end
    end
    wait_idle(name);
    checks++;
    if (upd_total - u0 !== 1) begin errors++; $display("FAIL %s upd_count: got %0d expected 1", name, upd_total - u0); end
  endtask

  task automatic test_reset();
    rst = 1'b1; hwag_start = 1'b1; main_edge = 1'b1;
    tick(2);
    checks++;
    if ({busy, upd, div_start, err_zero, err_tmo, overrun} !== 6'b0) begin
      errors++; $display("FAIL reset flags: got %b expected 000000", {busy, upd, div_start, err_zero, err_tmo, overrun});
    end
    checks++;
    if ({div_dividend, div_divider} !== '0) begin errors++; $display("FAIL reset div_bus: got %h expected 0", {div_dividend, div_divider}); end
    checks++;
    if (angle_set !== '0) begin errors++; $display("FAIL reset angle_set: got %h expected 0", angle_set); end
    main_edge = 1'b0; hwag_start = 1'b0;
    tick(1); rst = 1'b0; tick(2);
  endtask

  task automatic test_no_start_without_hwag();
    set_case(100, 50000, 4'hF, 4, 1'b0, 1'b0);
    pulse_edge(); tick(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL no_hwag busy: got %b expected 0", busy); end
    hwag_start = 1'b1; tick(2);
  endtask

  task automatic test_nominal();
    set_case(100, 50000, 4'hF, 24, 1'b0, 1'b0);
    run_pass("nominal", 1'b0);
    checks++;
    if ({err_zero, err_tmo, overrun} !== 3'b000) begin errors++; $display("FAIL nominal err_flags: got %b expected 000", {err_zero, err_tmo, overrun}); end
    commit_check("nominal");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      set_case(int'($urandom_range(1, 300)), 0, 4'($urandom_range(1, 15)), int'($urandom_range(1, 12)), 1'b0, 1'b1);
      run_pass("random", 1'b0);
      commit_check("random");
    end
  endtask

  task automatic test_partial_enable();
    set_case(100, 50000, 4'b0101, 5, 1'b0, 1'b0);
    run_pass("partial", 1'b0);
    commit_check("partial");
  endtask

  task automatic test_clamp();
    set_case(5, 50000, 4'hF, 8, 1'b0, 1'b0);
    run_pass("clamp", 1'b0);
    commit_check("clamp");
  endtask

  task automatic test_zero_period();
    checks++;
    if (err_zero !== 1'b0) begin errors++; $display("FAIL pre_zero err_zero: got %b expected 0", err_zero); end
    set_case(0, 50000, 4'hF, 8, 1'b0, 1'b0);
    run_pass("zero", 1'b0);
    commit_check("zero");
    checks++;
    if ({err_zero, err_tmo, overrun} !== 3'b100) begin errors++; $display("FAIL zero err_flags: got %b expected 100", {err_zero, err_tmo, overrun}); end
  endtask

  task automatic test_timeout_overrun();
    set_case(100, 0, 4'b1011, 8, 1'b1, 1'b1);
    run_pass("timeout", 1'b1);
    checks++;
    if ({err_tmo, overrun} !== 2'b11) begin errors++; $display("FAIL timeout err_tmo_overrun: got %b expected 11", {err_tmo, overrun}); end
    commit_check("timeout");
    never_rdy = 1'b0;
  endtask

  task automatic test_abort();
    int ds0, n, u0;
    set_case(100, 50000, 4'hF, 24, 1'b0, 1'b0);
    ds0 = ds_total;
    pulse_edge();
    n = 0;
    while (ds_total == ds0 && n < 50) begin @(negedge clk); n++; end
    if (ds_total == ds0) begin checks++; errors++; $display("FAIL abort no_div_start: got 0 pulses expected 1"); end
    tick(3);
    hwag_start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b expected 0", busy); end
    for (int c = 0; c < N_CH; c++) begin
      checks++;
      if (angle_set[c*WIDTH +: WIDTH] !== '0) begin errors++; $display("FAIL abort angle_set ch%0d: got %0d expected 0", c, angle_set[c*WIDTH +: WIDTH]); end
    end
    tick(2); hwag_start = 1'b1; tick(1);
    u0 = upd_total;
    pulse_edge(); tick(3);
    checks++;
    if (upd_total !== u0) begin errors++; $display("FAIL abort upd_after_edge: got %0d pulses expected 0", upd_total - u0); end
    checks++;
    if (angle_set !== '0) begin errors++; $display("FAIL abort angle_set_after_edge: got %h expected 0", angle_set); end
  endtask

  task automatic test_async_reset();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL async_rst precondition busy: got %b expected 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, err_zero, err_tmo, overrun, div_start} !== 5'b0) begin
      errors++; $display("FAIL async_rst flags: got %b expected 00000", {busy, err_zero, err_tmo, overrun, div_start});
    end
    checks++;
    if (div_divider !== '0) begin errors++; $display("FAIL async_rst div_divider: got %0d expected 0", div_divider); end
    @(negedge clk); rst = 1'b0; tick(2);
  endtask

  initial begin
    test_reset();
    test_no_start_without_hwag();
    test_nominal();
    test_random();
    test_partial_enable();
    test_clamp();
    test_zero_period();
    test_timeout_overrun();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
